// File: rtl/wb_pkg.sv
// wb_pkg: shared definitions for the write-back / trap-sequencing stage.
//   - RV32 major opcodes used by write-back formatting
//   - LOAD funct3 encodings
//   - mcause codes (interrupt codes get the MSB set by the user)
//   - FSM state enum and flush counter width
package wb_pkg;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   // exception codes
   localparam int unsigned CAUSE_INST_MIS = 0;
   localparam int unsigned CAUSE_ILLEGAL  = 2;
   localparam int unsigned CAUSE_LD_MIS   = 4;
   localparam int unsigned CAUSE_ST_MIS   = 6;
   // interrupt codes (MSB of mcause set on top)
   localparam int unsigned CAUSE_MSI      = 3;
   localparam int unsigned CAUSE_MTI      = 7;
   localparam int unsigned CAUSE_MEI      = 11;

   // flush counter width; FLUSH_CYCLES is limited to 1..15
   localparam int CNT_W = 4;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      TRAP_REQ = 2'd1,
      FLUSH    = 2'd2
   } wb_state_e;

endpackage

// File: rtl/wb_load_align.sv
// wb_load_align: combinational load-data formatting.
// Selects the byte/half addressed by addr_lo out of the aligned load word
// and sign- or zero-extends it according to the LOAD funct3.
// Ports:
//   mem_d   in  XLEN  raw aligned load word
//   addr_lo in  2     low byte-address bits
//   funct3  in  3     LB/LH/LW/LBU/LHU
//   data    out XLEN  formatted register-file data
module wb_load_align
   import wb_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] mem_d,
   input  logic [1:0]      addr_lo,
   input  logic [2:0]      funct3,
   output logic [XLEN-1:0] data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = mem_d[7:0];
      case (addr_lo)
         2'd0:    byte_sel = mem_d[7:0];
         2'd1:    byte_sel = mem_d[15:8];
         2'd2:    byte_sel = mem_d[23:16];
         default: byte_sel = mem_d[31:24];
      endcase
      half_sel = addr_lo[1] ? mem_d[31:16] : mem_d[15:0];
   end

   always_comb begin
      data = mem_d;
      case (funct3)
         F3_LB:   data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
         F3_LH:   data = {{(XLEN-16){half_sel[15]}}, half_sel};
         F3_LBU:  data = {{(XLEN-8){1'b0}}, byte_sel};
         F3_LHU:  data = {{(XLEN-16){1'b0}}, half_sel};
         F3_LW:   data = mem_d;
         default: data = mem_d;
      endcase
   end

endmodule

// File: rtl/wb_trap_ctrl.sv
// wb_trap_ctrl: write-back and trap sequencing at the end of the RV32 pipe.
// Formats the register-file write, picks the highest-priority trap for the
// retiring instruction, hands a trap record to the CSR file (valid/ack) and
// holds flush_o until the trap is acknowledged and a fixed drain elapses.
// Optional feature: define WB_IRQ_EN to let enabled interrupts trap;
// otherwise xint_*, mie_i and mstatus_mie_i are ignored.
// Ports:
//   clk_i, rst_i (sync, active-low)
//   valid_i, pc_i, instruction_i, alu_d_i, mem_d_i, mem_addr_i, csr_rdata_i
//   e_* exception flags, xint_* pending lines, mstatus_mie_i, mie_i{MEIE,MSIE,MTIE}
//   trap_ack_i                              CSR file committed the record
//   rd_o, rf_wd_o, we_rf_o                  register-file write (registered)
//   trap_valid_o, trap_cause_o, trap_epc_o, trap_tval_o   trap record
//   flush_o                                 squash younger stages
module wb_trap_ctrl
   import wb_pkg::*;
#(
   parameter int XLEN         = 32,
   parameter int RF_ADDR_W    = 5,
   parameter int FLUSH_CYCLES = 2
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 valid_i,
   input  logic [XLEN-1:0]      pc_i,
   input  logic [31:0]          instruction_i,
   input  logic [XLEN-1:0]      alu_d_i,
   input  logic [XLEN-1:0]      mem_d_i,
   input  logic [XLEN-1:0]      mem_addr_i,
   input  logic [XLEN-1:0]      csr_rdata_i,
   input  logic                 e_inst_addr_mis_i,
   input  logic                 e_illegal_inst_i,
   input  logic                 e_ld_addr_mis_i,
   input  logic                 e_st_addr_mis_i,
   input  logic                 xint_meip_i,
   input  logic                 xint_msip_i,
   input  logic                 xint_mtip_i,
   input  logic                 mstatus_mie_i,
   input  logic [2:0]           mie_i,
   input  logic                 trap_ack_i,
   output logic [RF_ADDR_W-1:0] rd_o,
   output logic [XLEN-1:0]      rf_wd_o,
   output logic                 we_rf_o,
   output logic                 trap_valid_o,
   output logic [XLEN-1:0]      trap_cause_o,
   output logic [XLEN-1:0]      trap_epc_o,
   output logic [XLEN-1:0]      trap_tval_o,
   output logic                 flush_o
);

   wb_state_e            state, state_n;
   logic [CNT_W-1:0]     cnt, cnt_n;

   logic [6:0]           opcode;
   logic [2:0]           funct3;
   logic [RF_ADDR_W-1:0] rd;
   logic [XLEN-1:0]      ld_data;
   logic [XLEN-1:0]      wb_data;
   logic                 wr_en;

   logic                 irq_mei, irq_msi, irq_mti;
   logic                 trap_hit;
   logic [XLEN-1:0]      cause_sel, tval_sel;

   logic                 wb_upd, wb_we_n, trap_take;

   assign opcode = instruction_i[6:0];
   assign funct3 = instruction_i[14:12];
   assign rd     = instruction_i[7 +: RF_ADDR_W];

   wb_load_align #(.XLEN(XLEN)) u_load_align (
      .mem_d   (mem_d_i),
      .addr_lo (mem_addr_i[1:0]),
      .funct3  (funct3),
      .data    (ld_data)
   );

   // write-back data and whether this opcode writes the register file at all
   always_comb begin
      wr_en   = 1'b0;
      wb_data = alu_d_i;
      case (opcode)
         OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC: wr_en = 1'b1;
         OPC_LOAD: begin
            wr_en   = 1'b1;
            wb_data = ld_data;
         end
         OPC_JAL, OPC_JALR: begin
            wr_en   = 1'b1;
            wb_data = pc_i + XLEN'(4);
         end
         OPC_SYSTEM: begin
            // funct3==0 covers ECALL/EBREAK/MRET/WFI: no register result
            if (funct3 != 3'b000) begin
               wr_en   = 1'b1;
               wb_data = csr_rdata_i;
            end
         end
         default: wr_en = 1'b0;
      endcase
   end

`ifdef WB_IRQ_EN
   assign irq_mei = xint_meip_i & mie_i[2] & mstatus_mie_i;
   assign irq_msi = xint_msip_i & mie_i[1] & mstatus_mie_i;
   assign irq_mti = xint_mtip_i & mie_i[0] & mstatus_mie_i;
`else
   logic unused_irq;
   assign unused_irq = ^{xint_meip_i, xint_msip_i, xint_mtip_i, mstatus_mie_i, mie_i};
   assign irq_mei = 1'b0;
   assign irq_msi = 1'b0;
   assign irq_mti = 1'b0;
`endif

   // trap priority: interrupts first, then exceptions in fixed order
   always_comb begin
      trap_hit  = 1'b1;
      cause_sel = '0;
      tval_sel  = '0;
      if (irq_mei) begin
         cause_sel = {1'b1, (XLEN-1)'(CAUSE_MEI)};
      end else if (irq_msi) begin
         cause_sel = {1'b1, (XLEN-1)'(CAUSE_MSI)};
      end else if (irq_mti) begin
         cause_sel = {1'b1, (XLEN-1)'(CAUSE_MTI)};
      end else if (e_inst_addr_mis_i) begin
         cause_sel = XLEN'(CAUSE_INST_MIS);
         tval_sel  = alu_d_i;
      end else if (e_illegal_inst_i) begin
         cause_sel = XLEN'(CAUSE_ILLEGAL);
         tval_sel  = XLEN'(instruction_i);
      end else if (e_ld_addr_mis_i) begin
         cause_sel = XLEN'(CAUSE_LD_MIS);
         tval_sel  = mem_addr_i;
      end else if (e_st_addr_mis_i) begin
         cause_sel = XLEN'(CAUSE_ST_MIS);
         tval_sel  = mem_addr_i;
      end else begin
         trap_hit  = 1'b0;
      end
   end

   // next-state / action decode
   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      wb_upd    = 1'b0;
      wb_we_n   = 1'b0;
      trap_take = 1'b0;
      case (state)
         RUN: begin
            if (valid_i) begin
               if (trap_hit) begin
                  trap_take = 1'b1;
                  state_n   = TRAP_REQ;
               end else begin
                  wb_upd  = 1'b1;
                  wb_we_n = wr_en & (rd != '0);
               end
            end
         end
         TRAP_REQ: begin
            if (trap_ack_i) begin
               state_n = FLUSH;
               cnt_n   = CNT_W'(FLUSH_CYCLES - 1);
            end
         end
         FLUSH: begin
            if (cnt == '0) state_n = RUN;
            else           cnt_n   = cnt - CNT_W'(1);
         end
         default: begin
            state_n = RUN;
            cnt_n   = '0;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state <= RUN;
         cnt   <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
      end
   end

   // registered outputs; status flags follow the next state so they line up
   // with the state the FSM is in during the following cycle
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         rd_o         <= '0;
         rf_wd_o      <= '0;
         we_rf_o      <= 1'b0;
         trap_valid_o <= 1'b0;
         trap_cause_o <= '0;
         trap_epc_o   <= '0;
         trap_tval_o  <= '0;
         flush_o      <= 1'b0;
      end else begin
         we_rf_o      <= wb_we_n;
         trap_valid_o <= (state_n == TRAP_REQ);
         flush_o      <= (state_n != RUN);
         if (wb_upd) begin
            rd_o    <= rd;
            rf_wd_o <= wb_data;
         end
         if (trap_take) begin
            trap_cause_o <= cause_sel;
            trap_epc_o   <= pc_i;
            trap_tval_o  <= tval_sel;
         end
      end
   end

endmodule

// File: tb/tb_wb_trap_ctrl.sv
// Directed bench for wb_trap_ctrl (default parameters, FLUSH_CYCLES=2).
module tb_wb_trap_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid;
   logic [31:0] pc, instr, alu_d, mem_d, mem_addr, csr_rdata;
   logic        e_iam, e_ill, e_lam, e_sam;
   logic        meip, msip, mtip, mstatus_mie;
   logic [2:0]  mie;
   logic        ack;
   logic [4:0]  rd;
   logic [31:0] rf_wd;
   logic        we_rf;
   logic        trap_valid;
   logic [31:0] trap_cause, trap_epc, trap_tval;
   logic        flush;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   wb_trap_ctrl #(.XLEN(32), .RF_ADDR_W(5), .FLUSH_CYCLES(2)) dut (
      .clk_i(clk), .rst_i(rst), .valid_i(valid), .pc_i(pc),
      .instruction_i(instr), .alu_d_i(alu_d), .mem_d_i(mem_d),
      .mem_addr_i(mem_addr), .csr_rdata_i(csr_rdata),
      .e_inst_addr_mis_i(e_iam), .e_illegal_inst_i(e_ill),
      .e_ld_addr_mis_i(e_lam), .e_st_addr_mis_i(e_sam),
      .xint_meip_i(meip), .xint_msip_i(msip), .xint_mtip_i(mtip),
      .mstatus_mie_i(mstatus_mie), .mie_i(mie), .trap_ack_i(ack),
      .rd_o(rd), .rf_wd_o(rf_wd), .we_rf_o(we_rf),
      .trap_valid_o(trap_valid), .trap_cause_o(trap_cause),
      .trap_epc_o(trap_epc), .trap_tval_o(trap_tval), .flush_o(flush)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // advance one clock; outputs are sampled 1 time unit after the edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_flags();
      e_iam = 0; e_ill = 0; e_lam = 0; e_sam = 0;
      meip = 0; msip = 0; mtip = 0; mstatus_mie = 0; mie = 3'b000;
   endtask

   // ack immediately and wait out the 2-cycle drain back to RUN
   task automatic drain();
      ack = 1; step();
      ack = 0; valid = 0; step();
      step();
   endtask

   initial begin
      rst = 0; valid = 0; pc = 0; instr = 0; alu_d = 0; mem_d = 0;
      mem_addr = 0; csr_rdata = 0; ack = 0;
      clr_flags();
      step(); step();
      chk("rst_rd", 32'(rd), 32'd0);
      chk("rst_wd", rf_wd, 32'd0);
      chk("rst_we", 32'(we_rf), 32'd0);
      chk("rst_tvalid", 32'(trap_valid), 32'd0);
      chk("rst_cause", trap_cause, 32'd0);
      chk("rst_flush", 32'(flush), 32'd0);
      rst = 1;

      // ADD x5
      valid = 1; instr = 32'h0000_02B3; alu_d = 32'h1234; step();
      chk("add_rd", 32'(rd), 32'd5);
      chk("add_wd", rf_wd, 32'h1234);
      chk("add_we", 32'(we_rf), 32'd1);
      // ADD x0
      instr = 32'h0000_0033; step();
      chk("add_x0_we", 32'(we_rf), 32'd0);

      // LB x6, byte 3
      instr = 32'h0000_0303; mem_addr = 32'h1003; mem_d = 32'h80FF_FFFF; step();
      chk("lb_wd", rf_wd, 32'hFFFF_FF80);
      chk("lb_we", 32'(we_rf), 32'd1);
      // LBU
      instr = 32'h0000_4303; step();
      chk("lbu_wd", rf_wd, 32'h0000_0080);
      // LH, upper half
      instr = 32'h0000_1303; mem_addr = 32'h1002; mem_d = 32'h80FF_1234; step();
      chk("lh_wd", rf_wd, 32'hFFFF_80FF);
      // CSRRW x7
      instr = 32'h0000_13F3; csr_rdata = 32'hCAFE; step();
      chk("csr_wd", rf_wd, 32'hCAFE);
      chk("csr_rd", 32'(rd), 32'd7);
      // store: no write
      instr = 32'h0000_2023; step();
      chk("store_we", 32'(we_rf), 32'd0);

      // illegal + load-misaligned: illegal wins
      instr = 32'hFFFF_FFFF; pc = 32'h100; mem_addr = 32'h44;
      e_ill = 1; e_lam = 1; step();
      chk("ill_tvalid", 32'(trap_valid), 32'd1);
      chk("ill_flush", 32'(flush), 32'd1);
      chk("ill_cause", trap_cause, 32'd2);
      chk("ill_tval", trap_tval, 32'hFFFF_FFFF);
      chk("ill_epc", trap_epc, 32'h100);
      chk("ill_we", 32'(we_rf), 32'd0);
      // younger ADD keeps arriving but must be ignored
      clr_flags(); instr = 32'h0000_02B3; alu_d = 32'h9999; pc = 32'h104;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("hold_tvalid", 32'(trap_valid), 32'd1);
         chk("hold_cause", trap_cause, 32'd2);
         chk("hold_epc", trap_epc, 32'h100);
         chk("hold_we", 32'(we_rf), 32'd0);
      end
      ack = 1; step();
      chk("ack_tvalid", 32'(trap_valid), 32'd0);
      chk("ack_flush1", 32'(flush), 32'd1);
      chk("ack_we", 32'(we_rf), 32'd0);
      ack = 0; step();
      chk("flush2", 32'(flush), 32'd1);
      chk("flush2_we", 32'(we_rf), 32'd0);
      step();
      chk("flush_end", 32'(flush), 32'd0);
      chk("flush_end_we", 32'(we_rf), 32'd0);
      step();
      chk("resume_we", 32'(we_rf), 32'd1);
      chk("resume_wd", rf_wd, 32'h9999);

      // interrupt vs exception
      instr = 32'hFFFF_FFFF; pc = 32'h300;
      meip = 1; mtip = 1; mie = 3'b111; mstatus_mie = 1; e_ill = 1; step();
`ifdef WB_IRQ_EN
      chk("irq_cause", trap_cause, 32'h8000_000B);
      chk("irq_tval", trap_tval, 32'd0);
`else
      chk("irq_cause", trap_cause, 32'd2);
      chk("irq_tval", trap_tval, 32'hFFFF_FFFF);
`endif
      chk("irq_epc", trap_epc, 32'h300);
      drain();
      valid = 1; mstatus_mie = 0; step();
      chk("irq_off_cause", trap_cause, 32'd2);
      chk("irq_off_tval", trap_tval, 32'hFFFF_FFFF);
      drain();
      clr_flags();

      // store-misaligned alone, then reset in the middle of the flush
      valid = 1; instr = 32'h0000_2023; pc = 32'h400; mem_addr = 32'h0000_0123;
      e_sam = 1; step();
      chk("st_cause", trap_cause, 32'd6);
      chk("st_tval", trap_tval, 32'h123);
      clr_flags(); valid = 0;
      ack = 1; step();
      ack = 0;
      chk("mid_flush", 32'(flush), 32'd1);
      rst = 0; step();
      chk("rst_flush_flush", 32'(flush), 32'd0);
      chk("rst_flush_tvalid", 32'(trap_valid), 32'd0);
      chk("rst_flush_cause", trap_cause, 32'd0);
      rst = 1;
      // JAL x1 at 0x200
      valid = 1; instr = 32'h0000_00EF; pc = 32'h200; step();
      chk("jal_wd", rf_wd, 32'h204);
      chk("jal_we", 32'(we_rf), 32'd1);
      chk("jal_rd", 32'(rd), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
